dmem_axi_bridge: RTL and testbench

- Data-side memory port of the 5-stage MIPS core. It turns the ME-stage load/store request into single-beat AXI3 read or write transactions.
- It drives `ME_ReqStall`, which the pipeline hazard unit consumes to freeze ME and earlier stages and flush WB. It returns load data to ME/WB.
- One transaction is outstanding at a time. `arlock/arcache/arprot` and their AW equivalents are tied off at the core top level, not here.

---
 rtl/cpu_defs.sv | 24 ++
 rtl/dmem_axi_bridge.sv | 181 ++++++++++++++++++
 tb/tb_dmem_axi_bridge.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared core definitions: memory-bridge FSM encoding and AXI3 constants used by
// both the instruction-side and data-side bridges.
package cpu_defs;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdD,
    StWrAw,
    StWrResp,
    StDone
  } mem_state_e;

  localparam logic [7:0] AxiLenSingle   = 8'd0;
  localparam logic [1:0] AxiBurstIncr   = 2'b01;
  localparam logic [3:0] AxiRdIdDefault = 4'd1;
  localparam logic [3:0] AxiWrIdDefault = 4'd1;

  // Byte/half/word request size to AXI AxSIZE encoding.
  function automatic logic [2:0] axi_size(input logic [1:0] me_size);
    return {1'b0, me_size};
  endfunction

endpackage

// File: rtl/dmem_axi_bridge.sv
// Data-side memory port: turns one ME-stage load/store into a single-beat AXI3
// read or write, stalling the pipeline until the transaction completes.
module dmem_axi_bridge
  import cpu_defs::*;
#(
  parameter logic [3:0] RD_ID = AxiRdIdDefault,
  parameter logic [3:0] WR_ID = AxiWrIdDefault
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ME_MemEn,
  input  logic [3:0]  ME_MemWen,
  input  logic [31:0] ME_Addr,
  input  logic [1:0]  ME_Size,
  input  logic [31:0] ME_WData,
  input  logic        ME_Except,
  output logic        ME_ReqStall,
  output logic [31:0] ME_RData,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  size_q, size_d;
  logic        discard_q, discard_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        req, busy, aw_hs, w_hs, drop;
  logic        unused_axi;

  assign req   = ME_MemEn & ~ME_Except;
  assign busy  = (state_q != StIdle) && (state_q != StDone);
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  // The owning instruction was flushed earlier in this transaction or is being flushed now.
  assign drop  = discard_q | ME_Except;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wstrb_d   = wstrb_q;
    size_d    = size_q;
    discard_d = discard_q | (busy & ME_Except);
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        if (req) begin
          addr_d    = ME_Addr;
          size_d    = axi_size(ME_Size);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (ME_MemWen == 4'b0000) begin
            state_d = StRdA;
          end else begin
            state_d = StWrAw;
            wdata_d = ME_WData;
            wstrb_d = ME_MemWen;
          end
        end
      end
      StRdA: begin
        if (arready) state_d = StRdD;
      end
      StRdD: begin
        if (rvalid) begin
          discard_d = 1'b0;
          if (drop) begin
            state_d = StIdle;
          end else begin
            rdata_d = rdata;
            state_d = StDone;
          end
        end
      end
      StWrAw: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (bvalid) begin
          discard_d = 1'b0;
          state_d   = drop ? StIdle : StDone;
        end
      end
      StDone: begin
        discard_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      size_q    <= 3'h0;
      discard_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wstrb_q   <= wstrb_d;
      size_q    <= size_d;
      discard_q <= discard_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // DONE releases the stall for exactly one cycle so the instruction advances.
  assign ME_ReqStall = (state_q == StIdle) ? req : (state_q != StDone);
  assign ME_RData    = rdata_q;

  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = AxiLenSingle;
  assign arsize  = size_q;
  assign arburst = AxiBurstIncr;
  assign arvalid = (state_q == StRdA);
  assign rready  = (state_q == StRdD);

  assign awid    = WR_ID;
  assign awaddr  = addr_q;
  assign awlen   = AxiLenSingle;
  assign awsize  = size_q;
  assign awburst = AxiBurstIncr;
  assign awvalid = (state_q == StWrAw) & ~aw_done_q;

  assign wid     = WR_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == StWrAw) & ~w_done_q;
  assign bready  = (state_q == StWrResp);

  assign unused_axi = ^{rresp, rlast, bresp};

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Bench for dmem_axi_bridge: a latency-configurable AXI slave plus a transaction-level
// model of what each load/store must produce on the bus and on the pipeline side.
module tb_dmem_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ME_MemEn, ME_Except, ME_ReqStall;
  logic [3:0]  ME_MemWen;
  logic [31:0] ME_Addr, ME_WData, ME_RData;
  logic [1:0]  ME_Size;
  logic [3:0]  arid, awid, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  dmem_axi_bridge #(.RD_ID(4'd1), .WR_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn),
    .ME_MemEn(ME_MemEn), .ME_MemWen(ME_MemWen), .ME_Addr(ME_Addr), .ME_Size(ME_Size),
    .ME_WData(ME_WData), .ME_Except(ME_Except), .ME_ReqStall(ME_ReqStall),
    .ME_RData(ME_RData),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave latency knobs (cycles of valid before ready / before response).
  int lat_ar, lat_aw, lat_w, lat_r, lat_b;
  int ar_age, aw_age, w_age, r_age, b_age;
  bit r_pend, b_pend, got_aw, got_w, resp_now;
  logic [31:0] r_val;
  logic [31:0] rd_q[$];

  // Observed transfers.
  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [13:0] cap_armisc, cap_awmisc;
  logic [3:0]  cap_wstrb;
  logic [4:0]  cap_wmisc;

  logic [31:0] exp_rdata = 32'h0;

  function automatic logic [3:0] strobes(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic clear_counts();
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
  endtask

  task automatic slave_clear();
    r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
    ar_age = 0; aw_age = 0; w_age = 0; r_age = 0; b_age = 0;
    rd_q.delete();
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = 0; rresp = 0; rlast = 0; bresp = 0;
  endtask

  // One cycle of slave behaviour; called just after a falling edge.
  task automatic step();
    arready = arvalid && (ar_age >= lat_ar);
    awready = awvalid && (aw_age >= lat_aw);
    wready  = wvalid && (w_age >= lat_w);
    rvalid  = r_pend && (r_age >= lat_r);
    rdata   = rvalid ? r_val : 32'h0;
    rlast   = rvalid;
    bvalid  = b_pend && (b_age >= lat_b);
    #1;
    resp_now = 0;
    if (rvalid && rready) begin
      r_pend = 0; r_cnt++; resp_now = 1;
    end else if (r_pend) r_age++;
    if (arvalid && arready) begin
      ar_cnt++;
      cap_araddr = araddr; cap_arsize = arsize; cap_armisc = {arid, arlen, arburst};
      r_pend = 1; r_age = 0;
      r_val = (rd_q.size() > 0) ? rd_q.pop_front() : $urandom;
    end
    ar_age = (arvalid && !arready) ? ar_age + 1 : 0;
    if (bvalid && bready) begin
      b_pend = 0; b_cnt++; resp_now = 1;
    end else if (b_pend) b_age++;
    if (awvalid && awready) begin
      aw_cnt++; got_aw = 1;
      cap_awaddr = awaddr; cap_awsize = awsize; cap_awmisc = {awid, awlen, awburst};
    end
    if (wvalid && wready) begin
      w_cnt++; got_w = 1;
      cap_wdata = wdata; cap_wstrb = wstrb; cap_wmisc = {wid, wlast};
    end
    aw_age = (awvalid && !awready) ? aw_age + 1 : 0;
    w_age  = (wvalid && !wready) ? w_age + 1 : 0;
    if (got_aw && got_w) begin
      got_aw = 0; got_w = 0; b_pend = 1; b_age = 0;
    end
  endtask

  task automatic run_txn(input bit st, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input logic [31:0] rd);
    int stall_cnt;
    bit done, resp_prev;
    logic [3:0] wen;
    wen = st ? strobes(sz, a[1:0]) : 4'b0000;
    clear_counts();
    if (!st) rd_q.push_back(rd);
    stall_cnt = 0; done = 0; resp_prev = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ME_MemEn = 1; ME_MemWen = wen; ME_Addr = a; ME_Size = sz; ME_WData = wd; ME_Except = 0;
      end
      step();
      if (ME_ReqStall) stall_cnt++;
      else begin
        done = 1;
        check_eq("done_after_resp", 32'(resp_prev), 32'd1);
      end
      resp_prev = resp_now;
    end
    check_eq("txn_done", 32'(done), 32'd1);
    check_eq("stall_min3", 32'(stall_cnt >= 3), 32'd1);
    if (!st) begin
      exp_rdata = rd;
      check_eq("ar_count", ar_cnt, 1);
      check_eq("aw_count_rd", aw_cnt + w_cnt, 0);
      check_eq("araddr", cap_araddr, a);
      check_eq("arsize", 32'(cap_arsize), {30'd0, sz});
      check_eq("ar_fixed", 32'(cap_armisc), {18'd0, 4'd1, 8'd0, 2'b01});
    end else begin
      check_eq("aw_count", aw_cnt, 1);
      check_eq("w_count", w_cnt, 1);
      check_eq("b_count", b_cnt, 1);
      check_eq("ar_count_wr", ar_cnt, 0);
      check_eq("awaddr", cap_awaddr, a);
      check_eq("awsize", 32'(cap_awsize), {30'd0, sz});
      check_eq("wdata", cap_wdata, wd);
      check_eq("wstrb", 32'(cap_wstrb), 32'(wen));
      check_eq("aw_fixed", 32'(cap_awmisc), {18'd0, 4'd1, 8'd0, 2'b01});
      check_eq("w_fixed", 32'(cap_wmisc), {27'd0, 4'd1, 1'b1});
    end
    check_eq("rdata_out", ME_RData, exp_rdata);
  endtask

  task automatic idle(input int n, input bit exc);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ME_MemEn = exc; ME_Except = exc;
      ME_MemWen = exc ? 4'($urandom_range(0, 15)) : 4'h0;
      step();
      check_eq("idle_stall", 32'(ME_ReqStall), 32'd0);
      check_eq("idle_valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
      check_eq("idle_rdata", ME_RData, exp_rdata);
    end
  endtask

  // Flush the owning instruction mid-transaction, then present a new load.
  task automatic flush_test(input bit st);
    logic [31:0] a_old, a_new, rd_old, rd_new, kept;
    bit done, kept_pending;
    int prev_resp, prev_ar;
    a_old = $urandom & 32'hFFFF_FFFC;
    a_new = a_old ^ 32'h0000_0100;
    rd_old = $urandom; rd_new = $urandom;
    lat_ar = 0; lat_aw = 0; lat_w = 0; lat_r = 3; lat_b = 3;
    clear_counts();
    if (!st) rd_q.push_back(rd_old);
    rd_q.push_back(rd_new);
    kept = exp_rdata; done = 0; kept_pending = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ME_MemEn = 1; ME_MemWen = st ? 4'hF : 4'h0; ME_Addr = a_old; ME_Size = 2'd2;
        ME_WData = $urandom; ME_Except = 0;
      end
      if (c == 2) ME_Except = 1;
      if (c == 3) begin
        ME_Except = 0; ME_MemWen = 4'h0; ME_Addr = a_new;
      end
      prev_resp = r_cnt + b_cnt;
      prev_ar = ar_cnt;
      step();
      if (kept_pending) begin
        check_eq("flush_rdata_kept", ME_RData, kept);
        kept_pending = 0;
      end
      if (prev_resp == 0 && (r_cnt + b_cnt) == 1) kept_pending = 1;
      if (ar_cnt > prev_ar && cap_araddr == a_new)
        check_eq("flush_new_ar_after_old", 32'(prev_resp >= 1), 32'd1);
      if (!ME_ReqStall) done = 1;
    end
    exp_rdata = rd_new;
    check_eq("flush_done", 32'(done), 32'd1);
    check_eq("flush_ar_count", ar_cnt, st ? 1 : 2);
    check_eq("flush_aw_count", aw_cnt, st ? 1 : 0);
    check_eq("flush_new_addr", cap_araddr, a_new);
    check_eq("flush_rdata_new", ME_RData, rd_new);
  endtask

  task automatic reset_test();
    lat_ar = 0; lat_aw = 0; lat_w = 0; lat_r = 0; lat_b = 6;
    clear_counts();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ME_MemEn = 1; ME_MemWen = 4'hF; ME_Addr = 32'h0000_2000; ME_Size = 2'd2;
        ME_WData = 32'h1234_5678; ME_Except = 0;
      end
      step();
    end
    check_eq("rst_pre_bready", 32'(bready), 32'd1);
    @(negedge clk);
    ME_MemEn = 0; ME_MemWen = 0; resetn = 0;
    #1;
    check_eq("rst_ctrl",
             {26'd0, arvalid, rready, awvalid, wvalid, bready, ME_ReqStall}, 32'd0);
    check_eq("rst_rdata", ME_RData, 32'd0);
    check_eq("rst_awaddr", awaddr, 32'd0);
    check_eq("rst_wstrb", 32'(wstrb), 32'd0);
    slave_clear();
    exp_rdata = 0;
    @(negedge clk);
    resetn = 1;
    idle(2, 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit st;
    logic [1:0] sz;
    logic [31:0] a;
    int gap;
    resetn = 0;
    ME_MemEn = 0; ME_MemWen = 0; ME_Addr = 0; ME_Size = 0; ME_WData = 0; ME_Except = 0;
    lat_ar = 0; lat_aw = 0; lat_w = 0; lat_r = 0; lat_b = 0;
    slave_clear();
    clear_counts();
    repeat (2) @(negedge clk);
    check_eq("reset_ctrl",
             {26'd0, arvalid, rready, awvalid, wvalid, bready, ME_ReqStall}, 32'd0);
    check_eq("reset_rdata", ME_RData, 32'd0);
    check_eq("reset_araddr", araddr, 32'd0);
    resetn = 1;

    lat_ar = 1; lat_r = 2;
    run_txn(0, 32'h1FC0_0010, 2'd2, 32'h0, 32'hDEAD_BEEF);
    idle(1, 0);

    lat_ar = 0; lat_r = 0; lat_w = 0; lat_aw = 2; lat_b = 1;
    run_txn(1, 32'h1FC0_0012, 2'd0, 32'h00AB_0000, 32'h0);

    lat_aw = 0; lat_w = 0; lat_b = 3;
    run_txn(1, 32'h0000_0100, 2'd2, $urandom, 32'h0);

    idle(4, 1);
    flush_test(0);
    idle(1, 0);
    flush_test(1);
    reset_test();

    for (int t = 0; t < 40; t++) begin
      lat_ar = $urandom_range(0, 3); lat_aw = $urandom_range(0, 3);
      lat_w  = $urandom_range(0, 3); lat_r  = $urandom_range(0, 3);
      lat_b  = $urandom_range(0, 3);
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      a = $urandom;
      if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
      else if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
      run_txn(st, a, sz, $urandom, $urandom);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
